// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: requester handshakes (ports 0 and 1) plus the single memory
// port. The slave modport is the arbiter. The master modport is its environment:
// the requesters and the memory, which drives mem_rdata.
interface dm_arbiter_if #(
  parameter int DW = 32
);
  // Requester port 0 (CPU load/store stage)
  logic          req0;
  logic          we0;
  logic [31:0]   addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic          err0;
  logic [DW-1:0] rdata0;

  // Requester port 1 (debug / program loader)
  logic          req1;
  logic          we1;
  logic [31:0]   addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic          err1;
  logic [DW-1:0] rdata1;

  // Status and memory port
  logic          busy;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output ack0, err0, rdata0,
    output ack1, err1, rdata1,
    output busy, mem_addr, mem_wdata, mem_wr
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  ack0, err0, rdata0,
    input  ack1, err1, rdata1,
    input  busy, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter and access sequencer for the byte-addressed,
// big-endian word data memory. Port 0 is the CPU load/store stage and port 1
// is the debug/program loader. One word access is in flight at a time:
// IDLE -> ACCESS -> DONE for a valid access, IDLE -> DONE for a rejected one.
// Optional feature macro: DM_ARB_RR_EN selects round-robin arbitration.
// When it is undefined, port 0 has fixed priority and no last-grant register exists.
module dm_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  dm_arbiter_if.slave bus
);

  // Accesses at or above this byte address would run past the end of memory.
  localparam logic [31:0] ADDR_LIMIT = (32'd1 << AW) - 32'd3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;

  // Winner selection for the current IDLE cycle
  logic          any_req;
  logic          win;
  logic          win_we;
  logic [31:0]   win_addr;
  logic [DW-1:0] win_wdata;
  logic          win_reject;
  logic          take;

  // Latched transaction
  logic          gnt_q;
  logic          we_q;
  logic          err_q;

  // Memory-side and read-data holding registers
  logic [31:0]   mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  assign any_req = bus.req0 | bus.req1;

`ifdef DM_ARB_RR_EN
  logic last_q;

  // Round-robin pick: on a tie, grant the port that was not granted last.
  always_comb begin
    win = bus.req1;
    if (bus.req0 && bus.req1) begin
      win = ~last_q;
    end
  end

  // Last-grant follows every grant, including rejected accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (take) begin
      last_q <= win;
    end
  end
`else
  // Fixed priority: port 0 wins whenever it is requesting.
  always_comb begin
    win = ~bus.req0;
  end
`endif

  // Route the winner's command and classify it as accepted or rejected.
  always_comb begin
    win_we    = bus.we0;
    win_addr  = bus.addr0;
    win_wdata = bus.wdata0;
    if (win) begin
      win_we    = bus.we1;
      win_addr  = bus.addr1;
      win_wdata = bus.wdata1;
    end
    win_reject = (win_addr[1:0] != 2'b00) || (win_addr >= ADDR_LIMIT);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the state-decoded handshake/strobe outputs.
  always_comb begin
    state_d    = state_q;
    take       = 1'b0;
    bus.ack0   = 1'b0;
    bus.ack1   = 1'b0;
    bus.err0   = 1'b0;
    bus.err1   = 1'b0;
    bus.mem_wr = 1'b0;
    bus.busy   = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (any_req) begin
          take    = 1'b1;
          state_d = win_reject ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_wr = we_q;
        state_d    = DONE;
      end
      DONE: begin
        // Requests are deliberately not looked at here; a held req is
        // picked up again in the following IDLE cycle.
        bus.ack0 = ~gnt_q;
        bus.ack1 = gnt_q;
        bus.err0 = ~gnt_q & err_q;
        bus.err1 = gnt_q & err_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch the granted transaction. The memory address/data registers load
  // only for accepted accesses, so a rejection leaves the memory port untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (take) begin
      gnt_q <= win;
      we_q  <= win_we;
      err_q <= win_reject;
      if (!win_reject) begin
        mem_addr_q  <= win_addr;
        mem_wdata_q <= win_wdata;
      end
    end
  end

  // Capture read data at the edge that ends ACCESS; the memory has
  // registered it on the preceding negedge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if ((state_q == ACCESS) && !we_q) begin
      if (gnt_q) begin
        rdata1_q <= bus.mem_rdata;
      end else begin
        rdata0_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: self-checking bench for dm_arbiter. A negedge-registered word
// memory sits behind the DUT. A transaction-level reference model predicts every
// cycle's outputs, and directed tables and sequences check fixed expectations.
module tb_dm_arbiter;
  localparam int AW = 10;
  localparam logic [1:0] K_IDLE = 2'd0;
  localparam logic [1:0] K_ACC  = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_arbiter_if #(.DW(32)) bus();

  dm_arbiter #(.AW(AW), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h00010001) ^ 32'hA5C30000;
  endfunction

  // ---------------- memory behind the DUT (registers on negedge) -------------
  logic [31:0] mem [256];
  bit          mem_ready = 1'b0;
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      mem_ready = 1'b1;
    end
    if (bus.mem_wr) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr[9:2]];
  end

  // ---------------- reference model ------------------------------------------
  // A granted transaction becomes a list of future cycle descriptors; the model
  // pops one per clock. The memory is a plain word array indexed by addr/4.
  typedef struct packed {
    logic [1:0]  kind;
    logic        port;
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cyc_t;

  cyc_t        pend[$];
  cyc_t        cur = '0;
  logic [31:0] m_mem [256];
  bit          m_ready = 1'b0;
  logic [31:0] exp_rd [2];
  logic [31:0] exp_maddr;
  logic [31:0] exp_mwdata;
  bit          m_last;
  bit          m_p;
  cyc_t        m_c;

  always @(posedge clk or negedge rst_n) begin
    if (!m_ready) begin
      for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
      m_ready = 1'b1;
    end
    if (!rst_n) begin
      pend.delete();
      cur        = '0;
      exp_rd[0]  = '0;
      exp_rd[1]  = '0;
      exp_maddr  = '0;
      exp_mwdata = '0;
      m_last     = 1'b1;
    end else begin
      if (cur.kind == K_ACC) begin
        if (cur.we) m_mem[cur.addr / 4] = cur.wdata;
        else        exp_rd[cur.port] = m_mem[cur.addr / 4];
      end
      if (cur.kind == K_IDLE && (bus.req0 || bus.req1)) begin
        if (bus.req0 && bus.req1) begin
`ifdef DM_ARB_RR_EN
          m_p = !m_last;
`else
          m_p = 1'b0;
`endif
        end else begin
          m_p = bus.req1;
        end
        m_last   = m_p;
        m_c      = '0;
        m_c.port = m_p;
        m_c.we   = m_p ? bus.we1 : bus.we0;
        m_c.addr = m_p ? bus.addr1 : bus.addr0;
        m_c.wdata = m_p ? bus.wdata1 : bus.wdata0;
        m_c.err  = (m_c.addr % 4 != 0) || (m_c.addr > 32'((1 << AW) - 4));
        if (!m_c.err) begin
          exp_maddr  = m_c.addr;
          exp_mwdata = m_c.wdata;
          m_c.kind   = K_ACC;
          pend.push_back(m_c);
        end
        m_c.kind = K_DONE;
        pend.push_back(m_c);
      end
      if (pend.size() > 0) cur = pend.pop_front();
      else                 cur = '0;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the clock edge.
  always @(posedge clk) begin
    #1;
    check("m_busy",   bus.busy,   32'(cur.kind != K_IDLE));
    check("m_mem_wr", bus.mem_wr, 32'(cur.kind == K_ACC && cur.we));
    check("m_ack0",   bus.ack0,   32'(cur.kind == K_DONE && cur.port == 1'b0));
    check("m_ack1",   bus.ack1,   32'(cur.kind == K_DONE && cur.port == 1'b1));
    if (cur.kind == K_DONE) begin
      check("m_err", cur.port ? bus.err1 : bus.err0, 32'(cur.err));
    end
    check("m_rdata0",    bus.rdata0,    exp_rd[0]);
    check("m_rdata1",    bus.rdata1,    exp_rd[1]);
    check("m_mem_addr",  bus.mem_addr,  exp_maddr);
    check("m_mem_wdata", bus.mem_wdata, exp_mwdata);
  end

  // ---------------- stimulus helpers -----------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int p, input bit r, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Issue one transaction from IDLE, wait (bounded) for its ack, drop req,
  // and return once the arbiter is back in IDLE.
  task automatic run_txn(input int p, input bit we, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output bit err,
                         output int wrcnt);
    set_req(p, 1'b1, we, a, d);
    lat   = -1;
    err   = 1'b0;
    wrcnt = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.mem_wr) wrcnt++;
      if ((p == 0 && bus.ack0) || (p == 1 && bus.ack1)) begin
        lat = n;
        err = (p == 0) ? bus.err0 : bus.err1;
        break;
      end
    end
    set_req(p, 1'b0, we, a, d);
    tick();
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'($urandom_range(0, 1100));
    return 32'($urandom_range(0, 15) * 4) + ((r == 1) ? 32'h3C0 : 32'h0);
  endfunction

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    int          exp_lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[10];

  int          lat;
  bit          err;
  int          wrcnt;
  int          nack;
  int          got;
  int          expp;
  int          first_port;
  bit          done0;
  bit          done1;

  initial begin
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;

    tbl[0] = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 2, 32'h0};
    tbl[1] = '{0, 1'b0, 32'h10,  32'h0,        1'b0, 2, 32'hDEADBEEF};
    tbl[2] = '{1, 1'b0, 32'h10,  32'h0,        1'b0, 2, 32'hDEADBEEF};
    tbl[3] = '{1, 1'b0, 32'h12,  32'h0,        1'b1, 1, 32'hDEADBEEF};
    tbl[4] = '{1, 1'b0, 32'h3FE, 32'h0,        1'b1, 1, 32'hDEADBEEF};
    tbl[5] = '{1, 1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0, 2, 32'hDEADBEEF};
    tbl[6] = '{1, 1'b0, 32'h3FC, 32'h0,        1'b0, 2, 32'hCAFEF00D};
    tbl[7] = '{0, 1'b0, 32'h400, 32'h0,        1'b1, 1, 32'hDEADBEEF};
    tbl[8] = '{0, 1'b1, 32'h3FD, 32'h12345678, 1'b1, 1, 32'hDEADBEEF};
    tbl[9] = '{0, 1'b0, 32'h0,   32'h0,        1'b0, 2, init_word(0)};

    // Reset state
    tick();
    check("rst_busy",   bus.busy,     32'd0);
    check("rst_mem_wr", bus.mem_wr,   32'd0);
    check("rst_ack",    {bus.ack0, bus.ack1, bus.err0, bus.err1}, 32'd0);
    check("rst_rdata0", bus.rdata0,   32'd0);
    check("rst_rdata1", bus.rdata1,   32'd0);
    check("rst_maddr",  bus.mem_addr, 32'd0);
    rst_n = 1'b1;

    // Directed table: write/read, misaligned, out-of-range and boundary accesses
    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, err, wrcnt);
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
      check($sformatf("tbl%0d_err", i), err, 32'(tbl[i].exp_err));
      check($sformatf("tbl%0d_wr", i), wrcnt, 32'(tbl[i].we && !tbl[i].exp_err));
      check($sformatf("tbl%0d_rd", i),
            (tbl[i].port == 0) ? bus.rdata0 : bus.rdata1, tbl[i].exp_rd);
    end

    // Both ports held high: grant order and 3-cycle ack spacing
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h44, 32'h0);
    nack = 0;
    for (int n = 1; n <= 60 && nack < 7; n++) begin
      tick();
      if (bus.ack0 || bus.ack1) begin
        got = bus.ack1 ? 1 : 0;
        if (nack < 6) begin
`ifdef DM_ARB_RR_EN
          expp = nack % 2;
`else
          expp = 0;
`endif
          check($sformatf("both_port%0d", nack), got, expp);
          check($sformatf("both_cyc%0d", nack), n, 2 + 3 * nack);
          if (nack == 5) bus.req0 = 1'b0;
        end else begin
          check("tail_port", got, 1);
          check("tail_cyc", n, 2 + 3 * 6);
          bus.req1 = 1'b0;
        end
        nack++;
      end
    end
    check("both_count", nack, 7);
    tick();

    // Write, then simultaneous reads from both ports
    run_txn(0, 1'b1, 32'h20, 32'h11223344, lat, err, wrcnt);
    check("wr20_lat", lat, 2);
    set_req(0, 1'b1, 1'b0, 32'h24, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h20, 32'h0);
    done0 = 1'b0;
    done1 = 1'b0;
    first_port = -1;
    for (int n = 1; n <= 30 && !(done0 && done1); n++) begin
      tick();
      if (bus.ack0) begin
        done0 = 1'b1; bus.req0 = 1'b0;
        if (first_port < 0) first_port = 0;
      end
      if (bus.ack1) begin
        done1 = 1'b1; bus.req1 = 1'b0;
        if (first_port < 0) first_port = 1;
      end
    end
    tick();
    check("same_done", {done0, done1}, 32'd3);
`ifdef DM_ARB_RR_EN
    check("same_first", first_port, 1);
`else
    check("same_first", first_port, 0);
`endif
    check("same_rdata1", bus.rdata1, 32'h11223344);
    check("same_rdata0", bus.rdata0, init_word(9));

    // Reset asserted during ACCESS of a write
    set_req(0, 1'b1, 1'b1, 32'h30, 32'h55AA55AA);
    tick();
    check("rstw_wr_before", bus.mem_wr, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstw_wr",   bus.mem_wr, 32'd0);
    check("rstw_busy", bus.busy,   32'd0);
    check("rstw_ack",  bus.ack0,   32'd0);
    bus.req0 = 1'b0;
    tick();
    check("rstw_ack_hold", bus.ack0, 32'd0);
    tick();
    rst_n = 1'b1;
    run_txn(0, 1'b0, 32'h30, 32'h0, lat, err, wrcnt);
    check("rstw_rd_lat",  lat, 2);
    check("rstw_rd_data", bus.rdata0, init_word(12));

    // Randomized traffic on both ports against the reference model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (bus.req0 && bus.ack0) begin
        if ($urandom_range(0, 1) == 1) set_req(0, 1'b1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
        else bus.req0 = 1'b0;
      end else if (!bus.req0 && $urandom_range(0, 3) == 0) begin
        set_req(0, 1'b1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
      end
      if (bus.req1 && bus.ack1) begin
        if ($urandom_range(0, 1) == 1) set_req(1, 1'b1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
        else bus.req1 = 1'b0;
      end else if (!bus.req1 && $urandom_range(0, 3) == 0) begin
        set_req(1, 1'b1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
